// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: byte-level I2C command sequencer driving a bit controller
module i2c_byte_sequencer #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             stop,
  input  logic             read,
  input  logic             write,
  input  logic             ack_in,
  input  logic [NBITS-1:0] din,
  output logic             cmd_ack,
  output logic             ack_out,
  output logic [NBITS-1:0] dout,
  output logic             i2c_al,
  output logic [3:0]       bit_cmd,
  input  logic             bit_ack,
  input  logic             bit_al,
  output logic             bit_din,
  input  logic             bit_dout
);
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {IDLE, START, WRITE, READ, ACK, STOP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       bit_cmd_q, bit_cmd_d;
  logic             bit_din_q, bit_din_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             ack_out_q, ack_out_d;
  logic             i2c_al_q;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             go;

  // a command is only accepted outside the cycle that acknowledges the previous one
  assign go      = (read | write | stop) & ~cmd_ack_q;
  assign cmd_ack = cmd_ack_q;
  assign ack_out = ack_out_q;
  assign dout    = sr_q;
  assign i2c_al  = i2c_al_q;
  assign bit_cmd = bit_cmd_q;
  assign bit_din = bit_din_q;

  // next-state: arbitration loss overrides everything, otherwise advance on bit_ack
  always_comb begin
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    if (bit_al) begin
      state_d   = IDLE;
      bit_cmd_d = CMD_NOP;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          sr_d      = din;
          cnt_d     = CW'(NBITS - 1);
          state_d   = start ? START : read ? READ : write ? WRITE : STOP;
          bit_cmd_d = start ? CMD_START : read ? CMD_READ : write ? CMD_WRITE : CMD_STOP;
        end
        START: if (bit_ack) begin
          state_d   = read ? READ : WRITE;
          bit_cmd_d = read ? CMD_READ : CMD_WRITE;
        end
        WRITE, READ: if (bit_ack) begin
          sr_d  = {sr_q[NBITS-2:0], bit_dout};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d   = ACK;
            bit_cmd_d = (state_q == WRITE) ? CMD_READ : CMD_WRITE;
            bit_din_d = (state_q == READ) ? ack_in : bit_din_q;
          end
        end
        ACK: if (bit_ack) begin
          ack_out_d = bit_dout;
          bit_din_d = 1'b1;
          state_d   = stop ? STOP : IDLE;
          bit_cmd_d = stop ? CMD_STOP : CMD_NOP;
          cmd_ack_d = ~stop;
        end
        STOP: if (bit_ack) begin
          state_d   = IDLE;
          bit_cmd_d = CMD_NOP;
          cmd_ack_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == WRITE) bit_din_d = sr_d[NBITS-1];
  end

  // state and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      bit_cmd_q <= CMD_NOP;
      bit_din_q <= 1'b1;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      i2c_al_q  <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      i2c_al_q  <= bit_al;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer: randomized transactions against a transaction-level model
module tb_i2c_byte_sequencer;
  localparam int N = 8;
  localparam logic [3:0] C_NOP = 4'b0000, C_STA = 4'b0001, C_STO = 4'b0010, C_WR = 4'b0100, C_RD = 4'b1000;

  logic clk = 1'b0, nReset = 1'b0;
  logic start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
  logic bit_ack = 1'b0, bit_al = 1'b0, bit_dout = 1'b0;
  logic [N-1:0] din = '0, dout;
  logic cmd_ack, ack_out, i2c_al, bit_din;
  logic [3:0] bit_cmd;

  int n_vec = 0, n_bad = 0, n_cack = 0;
  logic chk = 1'b0;
  logic [3:0] e_cmd = C_NOP;
  logic e_cack = 1'b0, e_aout = 1'b0, e_al = 1'b0, e_din = 1'b1, e_din_chk = 1'b1;
  logic [N-1:0] e_dout = '0;
  logic [3:0] obs_cmd[$];
  logic [N-1:0] obs_wd;

  i2c_byte_sequencer #(.NBITS(N)) dut (
    .clk(clk), .nReset(nReset), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .i2c_al(i2c_al), .bit_cmd(bit_cmd), .bit_ack(bit_ack), .bit_al(bit_al),
    .bit_din(bit_din), .bit_dout(bit_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, just after each active edge
  always @(posedge clk) begin
    #1;
    if (chk) begin
      check("bit_cmd", 32'(bit_cmd), 32'(e_cmd));
      check("cmd_ack", 32'(cmd_ack), 32'(e_cack));
      check("dout", 32'(dout), 32'(e_dout));
      check("ack_out", 32'(ack_out), 32'(e_aout));
      check("i2c_al", 32'(i2c_al), 32'(e_al));
      if (e_din_chk) check("bit_din", 32'(bit_din), 32'(e_din));
      if (cmd_ack) n_cack++;
    end
  end

  task automatic cyc(input logic a, input logic l, input logic b);
    @(negedge clk);
    bit_ack = a; bit_al = l; bit_dout = b; e_al = l; e_cack = 1'b0;
  endtask

  task automatic drop();
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // bit_din is defined on write data bits, the master ACK bit of a read, and after any ACK phase
  task automatic set_din(input int j, input logic data, input logic r, input logic ai,
                         input logic [N-1:0] d, input int fd, input int ak);
    if (!data) e_din_chk = 1'b0;
    else if (j > ak) begin e_din = 1'b1; e_din_chk = 1'b1; end
    else if (j == ak) begin e_din = ai; e_din_chk = r; end
    else if (j >= fd) begin e_din = d[N-1-(j-fd)]; e_din_chk = !r; end
    else e_din_chk = 1'b0;
  endtask

  task automatic txn(input logic s, input logic p, input logic r, input logic w, input logic ai,
                     input logic [N-1:0] d, input logic rnd, input logic [N-1:0] pat,
                     input int ab_step, input int ab_mode, input int rst_step);
    logic [3:0] seq[$];
    int fd, ak, nw;
    logic data, b, ab;
    data = s | r | w;
    seq = {};
    fd = -1; ak = -1; ab = 1'b0;
    if (data) begin
      if (s) seq.push_back(C_STA);
      fd = seq.size();
      for (int i = 0; i < N; i++) seq.push_back(r ? C_RD : C_WR);
      ak = seq.size();
      seq.push_back(r ? C_WR : C_RD);
    end
    if (p) seq.push_back(C_STO);
    obs_cmd = {}; obs_wd = '0; n_cack = 0;
    @(negedge clk);
    start = s; stop = p; read = r; write = w; ack_in = ai; din = d;
    bit_ack = 1'b0; bit_al = 1'b0; e_al = 1'b0; e_cack = 1'b0;
    e_cmd = seq[0]; e_dout = d;
    set_din(0, data, r, ai, d, fd, ak);
    for (int j = 0; j < seq.size(); j++) begin
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) cyc(1'b0, 1'b0, 1'b0);
      if (j == rst_step) begin
        @(negedge clk);
        nReset = 1'b0;
        #1;
        check("rst_async_bit_cmd", 32'(bit_cmd), 32'h0);
        check("rst_async_dout", 32'(dout), 32'h0);
        check("rst_async_bit_din", 32'(bit_din), 32'h1);
        check("rst_async_ack_out", 32'(ack_out), 32'h0);
        check("rst_async_cmd_ack", 32'(cmd_ack), 32'h0);
        check("rst_async_i2c_al", 32'(i2c_al), 32'h0);
        drop(); bit_ack = 1'b0; bit_al = 1'b0;
        e_cmd = C_NOP; e_cack = 1'b0; e_aout = 1'b0; e_dout = '0; e_din = 1'b1; e_din_chk = 1'b1; e_al = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        return;
      end
      if (j == ab_step) begin
        cyc(ab_mode == 2, 1'b1, 1'($urandom));
        e_cmd = C_NOP; e_din_chk = 1'b0;
        ab = 1'b1;
        break;
      end
      b = rnd ? 1'($urandom) : ((j >= fd && j < fd + N) ? pat[N-1-(j-fd)] : 1'b0);
      cyc(1'b1, 1'b0, b);
      obs_cmd.push_back(bit_cmd);
      if (data && j >= fd && j < fd + N) begin
        if (!r) obs_wd = {obs_wd[N-2:0], bit_din};
        e_dout = {e_dout[N-2:0], b};
      end
      if (j == ak) e_aout = b;
      e_cmd = (j + 1 < seq.size()) ? seq[j+1] : C_NOP;
      e_cack = (j + 1 == seq.size());
      set_din(j + 1, data, r, ai, d, fd, ak);
    end
    cyc(1'b0, 1'b0, 1'b0);
    if (!ab) cyc(1'b0, 1'b0, 1'b0);
    drop();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic s, p, r, w;
    repeat (2) @(negedge clk);
    check("reset_bit_cmd", 32'(bit_cmd), 32'h0);
    check("reset_bit_din", 32'(bit_din), 32'h1);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_cmd_ack", 32'(cmd_ack), 32'h0);
    nReset = 1'b1; chk = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    txn(1, 0, 0, 1, 0, 8'hA5, 0, 8'h00, -1, 0, -1);
    check("a5_bit_din_pattern", 32'(obs_wd), 32'hA5);
    check("a5_cmd_count", obs_cmd.size(), 10);
    check("a5_first_cmd", 32'(obs_cmd[0]), 32'h1);
    check("a5_last_cmd", 32'(obs_cmd[9]), 32'h8);
    check("a5_ack_out", 32'(ack_out), 32'h0);
    check("a5_cmd_ack_pulses", n_cack, 1);

    txn(0, 1, 1, 0, 1, 8'h5A, 0, 8'h3C, -1, 0, -1);
    check("rd_dout", 32'(dout), 32'h3C);
    check("rd_cmd_count", obs_cmd.size(), 10);
    check("rd_ack_cmd", 32'(obs_cmd[8]), 32'h4);
    check("rd_stop_cmd", 32'(obs_cmd[9]), 32'h2);
    check("rd_cmd_ack_pulses", n_cack, 1);

    txn(0, 1, 0, 0, 0, 8'h11, 1, 8'h00, -1, 0, -1);
    check("stop_only_cmds", obs_cmd.size(), 1);
    check("stop_only_cmd", 32'(obs_cmd[0]), 32'h2);
    check("stop_only_pulses", n_cack, 1);

    txn(0, 0, 0, 1, 0, 8'hC3, 1, 8'h00, 3, 1, -1);
    check("al_mid_no_cmd_ack", n_cack, 0);
    txn(0, 0, 0, 1, 0, 8'h96, 1, 8'h00, 7, 2, -1);
    check("al_last_no_cmd_ack", n_cack, 0);

    txn(0, 0, 1, 0, 0, 8'h00, 1, 8'h00, -1, 0, 4);
    check("rst_mid_no_cmd_ack", n_cack, 0);
    txn(0, 0, 0, 1, 0, 8'h3E, 1, 8'h00, -1, 0, -1);
    check("post_rst_write_pulses", n_cack, 1);

    txn(0, 0, 1, 1, 1, 8'h77, 1, 8'h00, -1, 0, -1);
    check("rw_prefers_read", 32'(obs_cmd[0]), 32'h8);

    for (int t = 0; t < 40; t++) begin
      {s, p, r, w} = 4'($urandom);
      if (!(r | w | p)) w = 1'b1;
      if ($urandom_range(0, 3) == 0)
        txn(s, p, r, w, 1'($urandom), N'($urandom), 1, '0, $urandom_range(0, 11), $urandom_range(1, 2), -1);
      else
        txn(s, p, r, w, 1'($urandom), N'($urandom), 1, '0, -1, 0, -1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
